image_pixel_streamer: RTL
=========================

IMAGE_PIXEL_STREAMER -- requirements
Module: image_pixel_streamer

Interface
REQ-001 Parameter IMG_W, default 4: image width in pixels, 1..320.
REQ-002 Parameter IMG_H, default 2: image height in pixels, 1..240.
REQ-003 Parameter COLOR_W, default 3: pixel color width in bits.
REQ-004 Parameter ADDR_W, default 17: image RAM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.
REQ-005 Parameter TRANSP_EN, default 0: 1 enables the transparent-color skip.
REQ-006 Parameter TRANSP_COLOR, default 3'b000: color value never plotted when TRANSP_EN=1.
REQ-007 Port clock, input, 1: the single clock; all logic on its rising edge.
REQ-008 Port reset, input, 1: reset, synchronous and active-high.
REQ-009 Port start, input, 1: request to draw the image once.
REQ-010 Port origin_x, input, 9: screen X of image pixel (0,0); sampled on start acceptance.
REQ-011 Port origin_y, input, 8: screen Y of image pixel (0,0); sampled on start acceptance.
REQ-012 Port mem_address, output, ADDR_W: registered read address to a synchronous image RAM with one-cycle read latency.
REQ-013 Port mem_q, input, COLOR_W: RAM read data.
REQ-014 Port vga_x, output, 9: registered plot X.
REQ-015 Port vga_y, output, 8: registered plot Y.
REQ-016 Port vga_color, output, COLOR_W: registered plot color.
REQ-017 Port plot, output, 1: write strobe to the VGA adapter; one pixel per high cycle.
REQ-018 Port busy, output, 1: high from start acceptance until done.
REQ-019 Port done, output, 1: single-cycle completion pulse.

Function
REQ-020 States: IDLE, SCAN, DRAIN; IDLE is the reset state.
REQ-021 start is accepted only in IDLE; at that edge (T) the block latches the origin, sets mem_address=0, busy=1, enters SCAN.
REQ-022 In SCAN, mem_address = row*IMG_W+col in row-major order; address k is presented after edge T+k, one per cycle, no gaps.
REQ-023 After address N-1 (N=IMG_W*IMG_H) is presented, the block enters DRAIN; no further addresses are issued.
REQ-024 A two-stage valid/coordinate pipeline tracks the one-cycle RAM latency: pixel k appears on vga_x/vga_y/vga_color after edge T+k+2.
REQ-025 vga_x = origin_x+col and vga_y = origin_y+row, computed at 10/9 bits internally; no wrap-around.
REQ-026 plot=1 for pixel k only if vga_x<320, vga_y<240, and (TRANSP_EN=0 or mem_q!=TRANSP_COLOR); otherwise plot=0 while coordinates still advance.
REQ-027 done pulses high for exactly one cycle after edge T+N+2; at the same edge busy falls and state returns to IDLE.
REQ-028 start asserted in the done cycle is accepted (back-to-back draws, no dead cycle beyond done).
REQ-029 start while busy is ignored; latched origin is unaffected.
REQ-030 IMG_W=IMG_H=1 is legal: one address, done after edge T+3.

Reset
REQ-031 Reset, synchronous and active-high, forces IDLE, mem_address=0, vga_x=0, vga_y=0, vga_color=0, plot=0, busy=0, done=0, and clears the pipeline valids.
REQ-032 Reset mid-SCAN or mid-DRAIN aborts with no further plot and no done pulse; start in the reset cycle is ignored.

Structure
REQ-033 Shared package holds SCREEN_W=320, SCREEN_H=240, X_W=9, Y_W=8, and the state enumeration.
REQ-034 Sub-module image_scan_counter: row/col/linear-address counter with a last-pixel flag; the FSM, pipeline, clip and transparency logic stay in the top.

Verification
REQ-035 IMG 4x2, origin (10,20), RAM holds 1..7,1: start -> 8 plots in consecutive cycles at (10..13,20),(10..13,21) with colors 1..7,1; done one cycle after the last plot.
REQ-036 TRANSP_EN=1, TRANSP_COLOR=0, RAM 0,5,0,5,...: start -> plot only at odd columns; address timing unchanged; done at T+10.
REQ-037 Origin (318,239), 4x2: start -> plots only at (318,239) and (319,239); done still at T+10.
REQ-038 Start pulsed again at T+3 with origin (0,0): ignored; all plots use (10,20); one done only.
REQ-039 Reset asserted at T+4: from the next edge plot=0, busy=0, mem_address=0; no done; a new start then runs a full 8-pixel draw.
REQ-040 Start held high continuously: draws repeat with done then immediate re-acceptance; period N+3 cycles.

Source files
------------

// File: rtl/image_pixel_streamer_pkg.sv
// Shared definitions for the image pixel streamer.
// Holds the screen geometry, the screen coordinate widths, the streamer
// state enumeration and a helper that sizes the scan counters.
package image_pixel_streamer_pkg;

    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;
    localparam int X_W      = 9;
    localparam int Y_W      = 8;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN
    } state_t;

    // Width of a counter that must hold 0..n-1 (at least one bit).
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/image_scan_counter.sv
// Row/column/linear-address counter for a row-major image scan.
// Ports:
//   clock, reset  - rising-edge clock, synchronous active-high reset
//   clear         - restart the scan at pixel (0,0), address 0
//   advance       - step to the next pixel
//   col, row      - current pixel position inside the image
//   addr          - current linear address (row*IMG_W + col)
//   last          - current pixel is the final one of the image
module image_scan_counter
    import image_pixel_streamer_pkg::*;
#(
    parameter int IMG_W  = 4,
    parameter int IMG_H  = 2,
    parameter int ADDR_W = 17,
    parameter int COL_W  = 2,
    parameter int ROW_W  = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              advance,
    output logic [COL_W-1:0]  col,
    output logic [ROW_W-1:0]  row,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);

    // The linear address is kept as its own incrementer rather than
    // derived as row*IMG_W+col, so no multiplier sits in the address path.
    // NOTE: state registers use non-blocking assignments and the reset is
    // tested inside the clocked block, which makes it synchronous.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else if (advance) begin
            addr <= addr + ADDR_W'(1);
            if (col == COL_MAX) begin
                col <= '0;
                row <= row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    assign last = (col == COL_MAX) && (row == ROW_MAX);

endmodule

// File: rtl/image_pixel_streamer.sv
// Streams an IMG_W x IMG_H image from a synchronous RAM to a VGA adapter.
// On start it reads every image pixel in row-major order and plots it at
// (origin_x+col, origin_y+row), skipping off-screen and (optionally)
// transparent pixels.
// Ports:
//   clock, reset           - rising-edge clock, synchronous active-high reset
//   start                  - draw request, accepted only when idle
//   origin_x, origin_y     - screen position of image pixel (0,0)
//   mem_address, mem_q     - image RAM read port (one-cycle read latency)
//   vga_x, vga_y,
//   vga_color, plot        - registered pixel write to the VGA adapter
//   busy                   - a draw is in progress
//   done                   - one-cycle pulse when a draw completes
module image_pixel_streamer
    import image_pixel_streamer_pkg::*;
#(
    parameter int                IMG_W        = 4,
    parameter int                IMG_H        = 2,
    parameter int                COLOR_W      = 3,
    parameter int                ADDR_W       = 17,
    parameter int                TRANSP_EN    = 0,
    parameter logic [COLOR_W-1:0] TRANSP_COLOR = '0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [X_W-1:0]     origin_x,
    input  logic [Y_W-1:0]     origin_y,
    output logic [ADDR_W-1:0]  mem_address,
    input  logic [COLOR_W-1:0] mem_q,
    output logic [X_W-1:0]     vga_x,
    output logic [Y_W-1:0]     vga_y,
    output logic [COLOR_W-1:0] vga_color,
    output logic               plot,
    output logic               busy,
    output logic               done
);

    localparam int COL_W = cnt_w(IMG_W);
    localparam int ROW_W = cnt_w(IMG_H);

    state_t            state;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic              last;
    logic              scan_clear;
    logic              scan_advance;

    logic [X_W-1:0]    org_x;
    logic [Y_W-1:0]    org_y;

    // Stage 1 runs alongside the RAM read: it holds the coordinates of the
    // pixel whose data is arriving on mem_q this cycle. Coordinates carry
    // one extra bit so an off-screen pixel never wraps back on screen.
    logic              s1_valid;
    logic              s1_last;
    logic [X_W:0]      s1_x;
    logic [Y_W:0]      s1_y;
    logic              out_last;
    logic              on_screen;
    logic              transparent;

    assign scan_clear   = (state == IDLE) && start;
    assign scan_advance = (state == SCAN) && !last;

    image_scan_counter #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W),
        .COL_W  (COL_W),
        .ROW_W  (ROW_W)
    ) u_scan (
        .clock   (clock),
        .reset   (reset),
        .clear   (scan_clear),
        .advance (scan_advance),
        .col     (col),
        .row     (row),
        .addr    (mem_address),
        .last    (last)
    );

    assign on_screen   = (s1_x < (X_W+1)'(SCREEN_W)) && (s1_y < (Y_W+1)'(SCREEN_H));
    assign transparent = (TRANSP_EN != 0) && (mem_q == TRANSP_COLOR);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            org_x     <= '0;
            org_y     <= '0;
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_x      <= '0;
            s1_y      <= '0;
            out_last  <= 1'b0;
            vga_x     <= '0;
            vga_y     <= '0;
            vga_color <= '0;
            plot      <= 1'b0;
        end else begin
            done <= 1'b0;

            // Every SCAN cycle presents exactly one address, so SCAN itself
            // is the stage-0 valid for the pixel on mem_address.
            s1_valid <= (state == SCAN);
            s1_last  <= (state == SCAN) && last;
            s1_x     <= {1'b0, org_x} + (X_W+1)'(col);
            s1_y     <= {1'b0, org_y} + (Y_W+1)'(row);
            out_last <= s1_last;

            // Coordinates advance for clipped/transparent pixels too; only
            // the strobe is suppressed.
            plot <= s1_valid && on_screen && !transparent;
            if (s1_valid) begin
                vga_x     <= s1_x[X_W-1:0];
                vga_y     <= s1_y[Y_W-1:0];
                vga_color <= mem_q;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        org_x <= origin_x;
                        org_y <= origin_y;
                        busy  <= 1'b1;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (last) state <= DRAIN;
                end
                DRAIN: begin
                    // The last pixel left the output stage on the previous
                    // edge; finishing now puts done one cycle after it.
                    if (out_last) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
